// File: rtl/exec_unit_seq.sv
// Three-phase request/response sequencer between the execute stage and NPORT valid/ready units.
// Define EXEC_UNIT_SEQ_TIMEOUT_EN to build the per-transaction timeout counter and err[0].
module exec_unit_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPE_W  = 4,
  parameter int unsigned NPORT  = 4,
  parameter int unsigned PORT_W = 2,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic [PORT_W-1:0]       req_port,
  input  logic [OPE_W-1:0]        req_ope,
  input  logic [DATA_W-1:0]       req_in1,
  input  logic [DATA_W-1:0]       req_in2,
  input  logic                    req_has_rsp,
  output logic [NPORT-1:0]        u_in_vld,
  input  logic [NPORT-1:0]        u_in_rdy,
  output logic [OPE_W-1:0]        u_ope,
  output logic [DATA_W-1:0]       u_in1,
  output logic [DATA_W-1:0]       u_in2,
  output logic [NPORT-1:0]        u_out_rdy,
  input  logic [NPORT-1:0]        u_out_vld,
  input  logic [NPORT*DATA_W-1:0] u_out_data,
  output logic                    rsp_vld,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  input  logic [TMO_W-1:0]        tmo_limit,
  output logic [7:0]              err,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q;
  logic [PORT_W-1:0]   port_q;
  logic                has_rsp_q;
  logic [2:0]          err_q;

  logic [NPORT-1:0]    req_sel;
  logic [NPORT-1:0]    cur_sel;
  logic [DATA_W-1:0]   out_sel_data;
  logic                port_ok;
  logic                in_hs;
  logic                out_hs;
  logic                spur;
  logic                busy;
  logic                tmo_hit;
  logic                tmo_fire;
  logic [2:0]          err_set;

`ifdef EXEC_UNIT_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = TMO_W + 1;
  logic [TMO_W-1:0] tmo_cnt_q;

  // Compare one bit wider so count + 1 never wraps into a false match.
  always_comb begin
    tmo_hit = (tmo_limit != '0) && ((CntW'(tmo_cnt_q) + CntW'(1)) == CntW'(tmo_limit));
  end
`else
  logic unused_tmo_limit;
  assign unused_tmo_limit = ^tmo_limit;

  always_comb begin
    tmo_hit = 1'b0;
  end
`endif

  always_comb begin
    req_sel      = '0;
    cur_sel      = '0;
    out_sel_data = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      req_sel[p] = (req_port == PORT_W'(p));
      cur_sel[p] = (port_q == PORT_W'(p));
      if (cur_sel[p]) out_sel_data = u_out_data[p*DATA_W +: DATA_W];
    end
    port_ok  = (32'(req_port) < NPORT);
    busy     = (state_q == StIssue) || (state_q == StWait);
    in_hs    = (state_q == StIssue) && (|(u_in_rdy & cur_sel));
    out_hs   = (state_q == StWait) && (|(u_out_vld & cur_sel));
    // Any result valid outside the one port we are waiting on is spurious.
    spur     = |(u_out_vld & ~((state_q == StWait) ? cur_sel : '0));
    tmo_fire = busy && tmo_hit && !in_hs && !out_hs;
    err_set  = {spur, (state_q == StIdle) && req_vld && !port_ok, tmo_fire};
  end

  assign err = {5'b0, err_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      port_q    <= '0;
      has_rsp_q <= 1'b0;
      req_rdy   <= 1'b1;
      u_in_vld  <= '0;
      u_out_rdy <= '0;
      u_ope     <= '0;
      u_in1     <= '0;
      u_in2     <= '0;
      rsp_vld   <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      err_q     <= '0;
`ifdef EXEC_UNIT_SEQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      rsp_vld <= 1'b0;
      err_q   <= (err_clr ? 3'b000 : err_q) | err_set;
`ifdef EXEC_UNIT_SEQ_TIMEOUT_EN
      if (state_q == StIdle) tmo_cnt_q <= '0;
      else if (busy)         tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
      case (state_q)
        StIdle: begin
          if (req_vld) begin
            port_q    <= req_port;
            has_rsp_q <= req_has_rsp;
            u_ope     <= req_ope;
            u_in1     <= req_in1;
            u_in2     <= req_in2;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            req_rdy   <= 1'b0;
            if (port_ok) begin
              u_in_vld <= req_sel;
              state_q  <= StIssue;
            end else begin
              rsp_err <= 1'b1;
              rsp_vld <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StIssue: begin
          if (in_hs) begin
            u_in_vld <= '0;
            if (has_rsp_q) begin
              u_out_rdy <= cur_sel;
              state_q   <= StWait;
            end else begin
              rsp_vld <= 1'b1;
              state_q <= StDone;
            end
          end else if (tmo_fire) begin
            u_in_vld <= '0;
            rsp_err  <= 1'b1;
            rsp_vld  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StWait: begin
          if (out_hs) begin
            u_out_rdy <= '0;
            rsp_data  <= out_sel_data;
            rsp_vld   <= 1'b1;
            state_q   <= StDone;
          end else if (tmo_fire) begin
            u_out_rdy <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_vld   <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          req_rdy <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_seq.sv
// Randomized self-checking bench for exec_unit_seq; the bench plays the units and predicts
// each transaction's latency, result and error bits from the handshake/timeout rules.
module tb_exec_unit_seq;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPE_W  = 4;
  localparam int unsigned NPORT  = 3;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned TMO_W  = 16;
`ifdef EXEC_UNIT_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    req_vld;
  logic                    req_rdy;
  logic [PORT_W-1:0]       req_port;
  logic [OPE_W-1:0]        req_ope;
  logic [DATA_W-1:0]       req_in1;
  logic [DATA_W-1:0]       req_in2;
  logic                    req_has_rsp;
  logic [NPORT-1:0]        u_in_vld;
  logic [NPORT-1:0]        u_in_rdy;
  logic [OPE_W-1:0]        u_ope;
  logic [DATA_W-1:0]       u_in1;
  logic [DATA_W-1:0]       u_in2;
  logic [NPORT-1:0]        u_out_rdy;
  logic [NPORT-1:0]        u_out_vld;
  logic [NPORT*DATA_W-1:0] u_out_data;
  logic                    rsp_vld;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic [TMO_W-1:0]        tmo_limit;
  logic [7:0]              err;
  logic                    err_clr;

  exec_unit_seq #(
    .DATA_W(DATA_W), .OPE_W(OPE_W), .NPORT(NPORT), .PORT_W(PORT_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_port(req_port),
    .req_ope(req_ope), .req_in1(req_in1), .req_in2(req_in2), .req_has_rsp(req_has_rsp),
    .u_in_vld(u_in_vld), .u_in_rdy(u_in_rdy), .u_ope(u_ope), .u_in1(u_in1), .u_in2(u_in2),
    .u_out_rdy(u_out_rdy), .u_out_vld(u_out_vld), .u_out_data(u_out_data),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err), .tmo_limit(tmo_limit),
    .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_err  = 8'h00;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 8'h00;
    check_eq("err_cleared", err, 8'h00);
  endtask

  // One transaction; the units react to the sampled handshake outputs each cycle.
  task automatic run_txn(input int port, input logic [OPE_W-1:0] ope, input logic [31:0] in1,
                         input logic [31:0] in2, input bit has_rsp, input int rdy_dly,
                         input int out_dly, input logic [31:0] rdata, input logic [15:0] tmo,
                         input int spur_at);
    int i_c, w_c, total, lat, w_spent, got_lat, seen_in, seen_out, spur_port;
    bit bad, hit, spur, exp_rerr;
    logic [31:0] exp_data;
    logic [NPORT-1:0] exp_oh;

    bad      = (port >= int'(NPORT));
    i_c      = rdy_dly + 1;
    w_c      = has_rsp ? out_dly + 1 : 0;
    total    = i_c + w_c;
    hit      = !bad && TmoEn && (tmo != 0) && (int'(tmo) < total) && (int'(tmo) != i_c);
    w_spent  = 0;
    exp_oh   = '0;
    spur     = 1'b0;
    if (bad) begin
      lat = 1; exp_rerr = 1'b1; exp_data = 32'h0;
      exp_err = exp_err | 8'h02;
    end else begin
      exp_oh[port] = 1'b1;
      if (hit) begin
        lat = int'(tmo) + 1; exp_rerr = 1'b1; exp_data = 32'h0;
        w_spent = (int'(tmo) > i_c) ? int'(tmo) - i_c : 0;
      end else begin
        lat = total + 1; exp_rerr = 1'b0; exp_data = has_rsp ? rdata : 32'h0;
        w_spent = w_c;
      end
      spur = (spur_at >= 0) && (spur_at < w_spent);
      if (spur) exp_err = 8'h04;
      if (hit) exp_err = exp_err | 8'h01;
    end
    spur_port = (port == 2) ? 0 : 2;

    @(negedge clk);
    check_eq("req_rdy_idle", req_rdy, 1'b1);
    req_vld     = 1'b1;
    req_port    = PORT_W'(port);
    req_ope     = ope;
    req_in1     = in1;
    req_in2     = in2;
    req_has_rsp = has_rsp;
    tmo_limit   = tmo;
    u_out_data  = {$urandom, $urandom, $urandom};
    if (!bad) u_out_data[port*DATA_W +: DATA_W] = rdata;
    @(posedge clk);

    got_lat  = 0;
    seen_in  = 0;
    seen_out = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      req_vld     = 1'b0;
      req_port    = PORT_W'($urandom);
      req_in1     = $urandom;
      req_in2     = $urandom;
      req_ope     = OPE_W'($urandom);
      req_has_rsp = 1'($urandom);
      u_in_rdy    = '0;
      u_out_vld   = '0;
      err_clr     = 1'b0;
      if (rsp_vld) begin
        got_lat = c;
        break;
      end
      check_eq("req_rdy_busy", req_rdy, 1'b0);
      if (u_in_vld != '0) begin
        check_eq("u_in_vld_onehot", u_in_vld, exp_oh);
        check_eq("u_ope_held", u_ope, ope);
        check_eq("u_in1_held", u_in1, in1);
        check_eq("u_in2_held", u_in2, in2);
        if (!bad && seen_in == rdy_dly) u_in_rdy[port] = 1'b1;
        seen_in++;
      end
      if (u_out_rdy != '0) begin
        check_eq("u_out_rdy_onehot", u_out_rdy, exp_oh);
        if (seen_out == spur_at) begin
          u_out_vld[spur_port] = 1'b1;
          err_clr = 1'b1;
        end
        if (!bad && seen_out == out_dly) u_out_vld[port] = 1'b1;
        seen_out++;
      end
    end
    check_eq("rsp_latency", got_lat, lat);
    if (got_lat != 0) begin
      check_eq("rsp_data", rsp_data, exp_data);
      check_eq("rsp_err", rsp_err, exp_rerr);
      check_eq("err", err, exp_err);
    end
    @(negedge clk);
    check_eq("rsp_one_cycle", rsp_vld, 1'b0);
    check_eq("req_rdy_after", req_rdy, 1'b1);
    check_eq("rsp_data_stable", rsp_data, exp_data);
    check_eq("handshake_idle", {u_in_vld, u_out_rdy}, '0);
  endtask

  // Accept a result-bearing request, grant it, then never return data for ncyc cycles.
  task automatic stuck_wait(input int port, input int ncyc, input logic [15:0] tmo);
    int rsp_cnt;
    logic [NPORT-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[port] = 1'b1;
    @(negedge clk);
    req_vld     = 1'b1;
    req_port    = PORT_W'(port);
    req_has_rsp = 1'b1;
    tmo_limit   = tmo;
    @(posedge clk);
    rsp_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      req_vld  = 1'b0;
      u_in_rdy = u_in_vld;
      if (rsp_vld) rsp_cnt++;
    end
    u_in_rdy = '0;
    check_eq("stuck_no_rsp", rsp_cnt, 0);
    check_eq("stuck_out_rdy", u_out_rdy, exp_oh);
  endtask

  task automatic reset_check();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 8'h00;
    check_eq("rst_u_out_rdy", u_out_rdy, '0);
    check_eq("rst_u_in_vld", u_in_vld, '0);
    check_eq("rst_req_rdy", req_rdy, 1'b1);
    check_eq("rst_rsp_vld", rsp_vld, 1'b0);
    check_eq("rst_err", err, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_port = '0; req_ope = '0; req_in1 = '0; req_in2 = '0;
    req_has_rsp = 1'b0; u_in_rdy = '0; u_out_vld = '0; u_out_data = '0; tmo_limit = '0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_req_rdy", req_rdy, 1'b1);
    check_eq("reset_handshake", {u_in_vld, u_out_rdy, rsp_vld, rsp_err}, '0);
    check_eq("reset_buses", {u_ope, u_in1, u_in2, rsp_data}, '0);
    check_eq("reset_err", err, 8'h00);
    rst = 1'b0;

    run_txn(0, 4'h1, 32'h3F800000, 32'h40000000, 1'b1, 0, 5, 32'h40400000, 16'd0, -1);
    run_txn(1, 4'h2, 32'h00000041, 32'h0, 1'b0, 10, 0, 32'h0, 16'd0, -1);
    run_txn(3, 4'h3, 32'h12345678, 32'h9ABCDEF0, 1'b1, 0, 0, 32'hDEADBEEF, 16'd0, -1);
    clear_err();
    run_txn(0, 4'h4, 32'hCAFE0000, 32'h0000BABE, 1'b1, 0, 4, 32'h600DF00D, 16'd0, 2);
    clear_err();
    // Handshake completing on the limit cycle wins over the timeout.
    run_txn(1, 4'h5, 32'h1, 32'h2, 1'b1, 1, 2, 32'h0BADCAFE, 16'd5, -1);
    run_txn(2, 4'h6, 32'h3, 32'h4, 1'b1, 2, 3, 32'h55AA55AA, 16'd3, -1);
    run_txn(0, 4'h7, 32'h5, 32'h6, 1'b0, 3, 0, 32'h0, 16'd3, -1);
`ifdef EXEC_UNIT_SEQ_TIMEOUT_EN
    clear_err();
    run_txn(2, 4'h8, 32'h0, 32'h0, 1'b1, 0, 5000, 32'h11111111, 16'd8, -1);
    clear_err();
    run_txn(3, 4'h0, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0, 16'd0, -1);
    stuck_wait(0, 5, 16'd0);
`else
    clear_err();
    run_txn(3, 4'h0, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0, 16'd0, -1);
    stuck_wait(2, 1000, 16'd8);
`endif
    reset_check();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 5) == 0) clear_err();
      run_txn($urandom_range(0, 3), OPE_W'($urandom), $urandom, $urandom,
              1'($urandom), $urandom_range(0, 4), $urandom_range(0, 6), $urandom,
              ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 12)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit_seq.md
# exec_unit_seq

Parametrised request/response sequencer for multi-cycle execution units: FPU, byte-IO in/out, and future units. It sits between the core's execute stage and up to NPORT valid/ready peripherals. It replaces the hard-coded FPU/IO stall sequencing with one generic three-phase handshake, adding per-transaction timeout and sticky error reporting. The core stalls while `req_rdy` is low and consumes `rsp_*` on the single cycle `rsp_vld` is high.

## Interface
- `DATA_W`, 32, operand/result width
- `OPE_W`, 4, opcode width forwarded to units
- `NPORT`, 4, number of unit ports (≥2)
- `PORT_W`, 2, width of `req_port` (≥ clog2(NPORT))
- `TMO_W`, 16, timeout counter width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_vld`  in  1  core issues transaction
- `req_rdy`  out  1  sequencer idle, can accept
- `req_port`  in  PORT_W  target unit index
- `req_ope`  in  OPE_W  unit opcode
- `req_in1`, `req_in2`  in  DATA_W  operands
- `req_has_rsp`  in  1  1 = unit returns a result (FPU, IN); 0 = fire-only (OUT)
- `u_in_vld`  out  NPORT  one-hot request valid
- `u_in_rdy`  in  NPORT  unit accepts request
- `u_ope`  out  OPE_W  registered opcode, shared
- `u_in1`, `u_in2`  out  DATA_W  registered operands, shared
- `u_out_rdy`  out  NPORT  one-hot result ready
- `u_out_vld`  in  NPORT  unit result valid
- `u_out_data`  in  NPORT*DATA_W  port p at bits [p*DATA_W +: DATA_W]
- `rsp_vld`  out  1  one-cycle completion pulse
- `rsp_data`  out  DATA_W  result (0 for fire-only or error)
- `rsp_err`  out  1  transaction aborted
- `tmo_limit`  in  TMO_W  timeout in cycles; 0 disables
- `err`  out  8  sticky: [0] timeout, [1] bad port, [2] spurious `u_out_vld`; [7:3] zero
- `err_clr`  in  1  clear `err`

## Operation
- States: IDLE, ISSUE, WAIT, DONE. On reset: IDLE; all outputs 0 except `req_rdy` = 1.
- IDLE: `req_rdy` = 1. `req_vld` latches port, ope, operands, has_rsp.
  - Valid port (`req_port` < NPORT): → ISSUE.
  - Invalid port: set err[1], force `rsp_err`, → DONE.
- ISSUE: `u_in_vld[p]` = 1 while `u_ope`/`u_in1`/`u_in2` are held. On `u_in_rdy[p]`:
  - `u_in_vld` drops next cycle.
  - has_rsp = 1: → WAIT.
  - has_rsp = 0: → DONE with `rsp_data` = 0.
- WAIT: `u_out_rdy[p]` = 1. On `u_out_vld[p]`, capture the port-p data slice into `rsp_data` and → DONE.
- DONE: `rsp_vld` = 1 for exactly one cycle, then → IDLE. `rsp_data`/`rsp_err` stay stable until the next accept. `rsp_err` clears on accept.
- Timeout counter:
  - Resets to 0 on accept; increments each cycle in ISSUE/WAIT.
  - When count + 1 == `tmo_limit` (nonzero) and the pending handshake does not complete that cycle: deassert `u_in_vld`/`u_out_rdy`, set err[0], `rsp_err` = 1, `rsp_data` = 0, → DONE.
  - A handshake completing in the same cycle wins over the timeout.
- Spurious result: `u_out_vld[q]` high where q ≠ p, or where the state is not WAIT, sets err[2]. The data is ignored.
- `err_clr`: clears `err` next cycle. If a new error occurs in the same cycle, the new bit is set (set wins).
- Only one transaction is outstanding at a time. The shared operand buses are driven only from latched values.

## Timing
- Best case with response:
  - Cycle 0: accept.
  - Cycle 1: ISSUE, handshake.
  - Cycle 2: WAIT, `u_out_vld`.
  - Cycle 3: `rsp_vld`.
  - Cycle 4: `req_rdy` = 1.
  - Issue-to-response latency is 3 cycles plus unit latency.
- Fire-only best case: `rsp_vld` in cycle 2.
- Bad port: `rsp_vld` in cycle 1.
- All outputs are registered; there is no combinational path from `u_*` inputs to `u_*` outputs.
- `rst` mid-transaction: next cycle in IDLE with all handshake outputs 0. The unit transaction is abandoned, and the unit must tolerate this.

## Configuration
- `EXEC_UNIT_SEQ_TIMEOUT_EN` defined: timeout counter and err[0] behave as above.
- Not defined: no counter is built, `tmo_limit` is ignored, err[0] is tied to 0, and ISSUE/WAIT wait indefinitely.

## Test plan
- FPU add, port 0, has_rsp = 1, in1 = 32'h3F800000, in2 = 32'h40000000; unit rdy immediately, out_vld 5 cycles later with 32'h40400000 → `rsp_vld` once, `rsp_data` = 32'h40400000, `rsp_err` = 0, `req_rdy` low from cycle 1 until the cycle after `rsp_vld`.
- OUT, port 1, has_rsp = 0, in1 = 8'h41; `u_in_rdy[1]` held low 10 cycles → `u_in_vld` = 4'b0010 stable with `u_in1` = 32'h41 throughout; `rsp_vld` 1 cycle after the handshake; `rsp_data` = 0.
- IN, port 2, `tmo_limit` = 8, unit never returns data (macro defined) → `rsp_vld` with `rsp_err` = 1, err = 8'h01; `err_clr` → err = 0. Repeat with the macro undefined → still waiting after 1000 cycles.
- `req_port` = 3 with NPORT = 3 → no `u_in_vld` asserted, `rsp_vld` next cycle, `rsp_err` = 1, err[1] = 1.
- `u_out_vld[3]` pulsed during port-0 WAIT, with `err_clr` asserted the same cycle → err[2] = 1, the port-0 result is still delivered correctly.
- `rst` asserted in WAIT → next cycle `u_out_rdy` = 0, `req_rdy` = 1, `rsp_vld` = 0, err = 0.
